mem_port_arbiter: RTL

Two-requester arbiter that shares the single data-memory port between the instruction-side MMU (I) and the data-side MMU (D). Each MMU holds its request across a whole multi-beat transaction: page-table walk beats plus the final physical access. The arbiter locks the port to one owner for that whole span. It hands over with round-robin fairness and drains any in-flight beat before re-granting. It sits between the two MMUs and the memory.

---
 rtl/mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single data-memory port between the
// instruction-side MMU (I) and the data-side MMU (D).
//
// An owner keeps the port for as long as its request stays high, which covers
// a whole page-table walk plus the final access. Hand-over is round-robin on
// ties. A beat still in flight when the owner lets go is drained, and its
// response is discarded, before the port is granted again. Every hand-over
// passes through IDLE, so there is always one bubble cycle between owners.
module mem_port_arbiter #(
    parameter int AW = 64,
    parameter int MW = 8
) (
    input  logic          clk,
    input  logic          rst,

    // Instruction-side MMU
    input  logic          re_i,
    input  logic          we_i,
    input  logic [AW-1:0] address_i,
    input  logic [AW-1:0] wdata_i,
    input  logic [MW-1:0] wmask_i,

    // Data-side MMU
    input  logic          re_d,
    input  logic          we_d,
    input  logic [AW-1:0] address_d,
    input  logic [AW-1:0] wdata_d,
    input  logic [MW-1:0] wmask_d,

    // Grants and routed responses
    output logic          gnt_i,
    output logic          gnt_d,
    output logic          rvalid_i,
    output logic          rvalid_d,
    output logic [AW-1:0] rdata,

    // Memory side
    output logic [AW-1:0] address,
    output logic          re_mem,
    output logic          we_mem,
    output logic [AW-1:0] wdata_mem,
    output logic [MW-1:0] wmask_mem,
    input  logic [AW-1:0] rdata_mem,
    input  logic          mem_rvalid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_I = 2'd1,
        ST_OWN_D = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Owner encoding used by last_q: 0 = I, 1 = D.
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    state_e state_q;
    state_e state_d;
    logic   last_q;
    logic   last_d;
    logic   outst_q;
    logic   outst_d;

    logic   req_i_s;
    logic   req_d_s;
    logic   release_clean_s;
    logic   outst_upd_s;

    // A side is requesting when it wants either a read or a write.
    always_comb begin
        req_i_s = re_i | we_i;
        req_d_s = re_d | we_d;
    end

    // On release the port can return straight to IDLE only when nothing is
    // left in flight: either no beat is outstanding and no response is
    // arriving, or the one outstanding beat is returning in this very cycle.
    // Any other combination leaves a response still to come, which is drained.
    always_comb begin
        release_clean_s = (~outst_q & ~mem_rvalid) | (outst_q & mem_rvalid);
    end

    // Outstanding-beat tracker: a response retires the beat; an issued beat
    // without a same-cycle response leaves one in flight.
    always_comb begin
        if (mem_rvalid) begin
            outst_upd_s = 1'b0;
        end else if (re_mem | we_mem) begin
            outst_upd_s = 1'b1;
        end else begin
            outst_upd_s = outst_q;
        end
    end

    // Next-state logic: arbitration in IDLE, lock while owned, drain on release.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                // On a tie the side that did not own the port last time wins.
                if (req_i_s && (!req_d_s || (last_q == OWNER_D))) begin
                    state_d = ST_OWN_I;
                end else if (req_d_s) begin
                    state_d = ST_OWN_D;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN_I: begin
                if (req_i_s) begin
                    state_d = ST_OWN_I;
                end else begin
                    last_d = OWNER_I;
                    if (release_clean_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_OWN_D: begin
                if (req_d_s) begin
                    state_d = ST_OWN_D;
                end else begin
                    last_d = OWNER_D;
                    if (release_clean_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // In-flight tracking is forgotten whenever the port goes back to IDLE.
    always_comb begin
        if (state_d == ST_IDLE) begin
            outst_d = 1'b0;
        end else begin
            outst_d = outst_upd_s;
        end
    end

    // State registers with synchronous reset. After reset last_q names D,
    // so I wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= OWNER_D;
            outst_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            outst_q <= outst_d;
        end
    end

    // Port mux: the owner's request reaches memory combinationally. In the
    // release cycle the owner's re/we are already low, and re_mem/we_mem are
    // forced low as well. IDLE and DRAIN present an all-zero port.
    always_comb begin
        gnt_i     = 1'b0;
        gnt_d     = 1'b0;
        rvalid_i  = 1'b0;
        rvalid_d  = 1'b0;
        address   = '0;
        re_mem    = 1'b0;
        we_mem    = 1'b0;
        wdata_mem = '0;
        wmask_mem = '0;
        case (state_q)
            ST_OWN_I: begin
                gnt_i     = 1'b1;
                rvalid_i  = mem_rvalid;
                address   = address_i;
                wdata_mem = wdata_i;
                wmask_mem = wmask_i;
                if (req_i_s) begin
                    re_mem = re_i;
                    we_mem = we_i;
                end else begin
                    re_mem = 1'b0;
                    we_mem = 1'b0;
                end
            end
            ST_OWN_D: begin
                gnt_d     = 1'b1;
                rvalid_d  = mem_rvalid;
                address   = address_d;
                wdata_mem = wdata_d;
                wmask_mem = wmask_d;
                if (req_d_s) begin
                    re_mem = re_d;
                    we_mem = we_d;
                end else begin
                    re_mem = 1'b0;
                    we_mem = 1'b0;
                end
            end
            ST_IDLE, ST_DRAIN: begin
                // The port stays idle; a stale response is dropped here.
                gnt_i = 1'b0;
                gnt_d = 1'b0;
            end
            default: begin
                gnt_i = 1'b0;
                gnt_d = 1'b0;
            end
        endcase
    end

    // Read data goes to both sides; each consumer qualifies it with its rvalid.
    always_comb begin
        rdata = rdata_mem;
    end

endmodule
